// File: rtl/kr_fec_frame_ctrl.sv
// KR FEC frame controller: numbers incoming 65-bit blocks into FEC frames,
// requests parity insertion at each frame boundary and counts finished frames.
module kr_fec_frame_ctrl #(
  parameter int BLK_PER_FRAME = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fec_en,
  input  logic        blk_ena,
  input  logic        par_ack,
  input  logic        err_clr,
  output logic        blk_rdy,
  output logic        blk_vld,
  output logic [4:0]  blk_idx,
  output logic        sof,
  output logic        eof,
  output logic        par_req,
  output logic        fec_active,
  output logic [15:0] frame_cnt,
  output logic        ovf_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    RUN      = 2'd2,
    WAIT_PAR = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(BLK_PER_FRAME - 1);

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic [4:0] out_idx_nxt;
  logic       vld_nxt, sof_nxt, eof_nxt;
  logic       accept, ack;

  // Handshake: a block transfers when blk_ena && blk_rdy; blk_ena while
  // blk_rdy is low drops the block and flags ovf_err. par_req is a
  // level request that completes on the first cycle par_ack is seen with it.
  assign blk_rdy   = (state != WAIT_PAR);
  assign accept    = blk_ena & blk_rdy;
  assign ack       = par_req & par_ack;
  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    vld_nxt     = accept;
    out_idx_nxt = 5'd0;
    sof_nxt     = 1'b0;
    eof_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (fec_en) state_nxt = ARM;
      end
      ARM: begin
        if (accept) begin
          sof_nxt   = 1'b1;
          idx_nxt   = 5'd1;
          state_nxt = RUN;
        end else if (!fec_en) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (accept) begin
          out_idx_nxt = idx;
          sof_nxt     = (idx == 5'd0);
          eof_nxt     = (idx == LAST_IDX);
          if (idx == LAST_IDX) begin
            idx_nxt   = 5'd0;
            state_nxt = WAIT_PAR;
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
      WAIT_PAR: begin
        // fec_en is only consulted here, so a disable never cuts a frame short
        if (ack) state_nxt = fec_en ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 5'd0;
      blk_vld    <= 1'b0;
      blk_idx    <= 5'd0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      par_req    <= 1'b0;
      fec_active <= 1'b0;
      frame_cnt  <= 16'd0;
      ovf_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      blk_vld    <= vld_nxt;
      blk_idx    <= out_idx_nxt;
      sof        <= sof_nxt;
      eof        <= eof_nxt;
      fec_active <= (state_nxt != IDLE);
      if (eof_nxt) par_req <= 1'b1;
      else if (ack) par_req <= 1'b0;
      if (ack) frame_cnt <= frame_cnt + 16'd1;
      if (blk_ena && !blk_rdy) ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kr_fec_frame_ctrl.sv
// Bench for kr_fec_frame_ctrl: 32-block instance driven by sequences with a
// block scoreboard, 2-block instance driven by a vector table and a wrap run.
module tb_kr_fec_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, fec_en, blk_ena, par_ack, err_clr;
  logic        blk_rdy, blk_vld, sof, eof, par_req, fec_active, ovf_err;
  logic [4:0]  blk_idx;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  logic        rst_s, fec_en_s, blk_ena_s, par_ack_s, err_clr_s;
  logic        blk_rdy_s, blk_vld_s, sof_s, eof_s, par_req_s, fec_active_s, ovf_err_s;
  logic [4:0]  blk_idx_s;
  logic [15:0] frame_cnt_s;
  logic [1:0]  dbg_state_s;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_exp;

  typedef struct {
    logic f, b, a, c;
    logic vld; logic [4:0] idx; logic sof, eof, preq, rdy, act, ovf;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[17];

  kr_fec_frame_ctrl #(.BLK_PER_FRAME(32)) dut (
    .clk(clk), .rst(rst), .fec_en(fec_en), .blk_ena(blk_ena), .par_ack(par_ack),
    .err_clr(err_clr), .blk_rdy(blk_rdy), .blk_vld(blk_vld), .blk_idx(blk_idx),
    .sof(sof), .eof(eof), .par_req(par_req), .fec_active(fec_active),
    .frame_cnt(frame_cnt), .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  kr_fec_frame_ctrl #(.BLK_PER_FRAME(2)) dut_s (
    .clk(clk), .rst(rst_s), .fec_en(fec_en_s), .blk_ena(blk_ena_s), .par_ack(par_ack_s),
    .err_clr(err_clr_s), .blk_rdy(blk_rdy_s), .blk_vld(blk_vld_s), .blk_idx(blk_idx_s),
    .sof(sof_s), .eof(eof_s), .par_req(par_req_s), .fec_active(fec_active_s),
    .frame_cnt(frame_cnt_s), .ovf_err(ovf_err_s), .dbg_state(dbg_state_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {blk_vld, blk_idx, sof, eof, par_req, fec_active, ovf_err, blk_rdy};
  endfunction

  function automatic vec_t mk(input logic f, b, a, c, vld, input logic [4:0] idx,
                              input logic so, eo, preq, rdy, act, ovf, input logic [15:0] cnt);
    vec_t v;
    v.f = f; v.b = b; v.a = a; v.c = c; v.vld = vld; v.idx = idx; v.sof = so; v.eof = eo;
    v.preq = preq; v.rdy = rdy; v.act = act; v.ovf = ovf; v.cnt = cnt;
    return v;
  endfunction

  // driver tasks
  task automatic step(input logic f, b, a, c);
    fec_en = f; blk_ena = b; par_ack = a; err_clr = c;
    @(posedge clk); #2;
  endtask

  task automatic step_s(input logic f, b, a, c);
    fec_en_s = f; blk_ena_s = b; par_ack_s = a; err_clr_s = c;
    @(posedge clk); #2;
  endtask

  // scoreboard monitor on the forwarded block stream of the 32-block instance
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && blk_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL blk_unexpected: got idx=%0d sof=%0b eof=%0b expected no block", blk_idx, sof, eof);
        end else begin
          mon_exp = exp_q.pop_front();
          check("blk_stream", {25'd0, blk_idx, sof, eof}, {25'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    int n, side, preq_n, rdy_lo, act_lo, k, cyc, v0;
    logic f_r, b_r;
    logic [15:0] last_cnt;
    logic [4:0] idx_m;

    rst = 1'b1; fec_en = 0; blk_ena = 0; par_ack = 0; err_clr = 0;
    rst_s = 1'b1; fec_en_s = 0; blk_ena_s = 0; par_ack_s = 0; err_clr_s = 0;

    //                 f  b  a  c  vld idx  sof eof preq rdy act ovf cnt
    vecs[0]  = mk(0, 1, 0, 0, 1, 5'd0, 0, 0, 0, 1, 0, 0, 16'd0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 5'd0, 0, 0, 0, 1, 1, 0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 16'd0);
    vecs[3]  = mk(1, 1, 0, 0, 1, 5'd0, 1, 0, 0, 1, 1, 0, 16'd0);
    vecs[4]  = mk(1, 1, 0, 0, 1, 5'd1, 0, 1, 1, 0, 1, 0, 16'd0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 1, 16'd0);
    vecs[6]  = mk(1, 0, 0, 1, 0, 5'd0, 0, 0, 1, 0, 1, 0, 16'd0);
    vecs[7]  = mk(1, 1, 0, 1, 0, 5'd0, 0, 0, 1, 0, 1, 1, 16'd0);
    vecs[8]  = mk(1, 0, 1, 0, 0, 5'd0, 0, 0, 0, 1, 1, 1, 16'd1);
    vecs[9]  = mk(1, 1, 0, 0, 1, 5'd0, 1, 0, 0, 1, 1, 1, 16'd1);
    vecs[10] = mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 1, 16'd1);
    vecs[11] = mk(0, 1, 0, 0, 1, 5'd1, 0, 1, 1, 0, 1, 1, 16'd1);
    vecs[12] = mk(0, 0, 1, 0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 16'd2);
    vecs[13] = mk(0, 1, 1, 0, 1, 5'd0, 0, 0, 0, 1, 0, 1, 16'd2);
    vecs[14] = mk(0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 1, 0, 0, 16'd2);
    vecs[15] = mk(1, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 16'd2);
    vecs[16] = mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 16'd2);

    // reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_outs", {20'd0, outs()}, 32'h001);
    check("reset_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;

    // bypass
    side = 0; v0 = vld_cnt;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(7'd0);
      step(0, 1, 0, 0);
      if (par_req || fec_active || sof || eof || !blk_rdy) side++;
    end
    check("bypass_ctrl", side, 0);
    check("bypass_pulses", vld_cnt - v0, 10);

    // full frame with ack tied high, then the next frame restarts at 0
    step(1, 0, 1, 0);
    check("arm_active", {31'd0, fec_active}, 32'd1);
    preq_n = 0; rdy_lo = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i < 32) exp_q.push_back({5'(i), i == 0, i == 31});
      else if (i >= 33) exp_q.push_back({5'(i - 33), i == 33, 1'b0});
      step(1, 1, 1, 0);
      preq_n += int'(par_req);
      rdy_lo += int'(!blk_rdy);
    end
    check("full_preq_cycles", preq_n, 1);
    check("full_rdy_low", rdy_lo, 1);
    check("full_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("full_ovf_drop", {31'd0, ovf_err}, 32'd1);

    // delayed ack, overflow and clear
    step(1, 0, 0, 1);
    check("ovf_clear_1", {31'd0, ovf_err}, 32'd0);
    preq_n = 0;
    for (int i = 8; i < 32; i++) begin
      exp_q.push_back({5'(i), 1'b0, i == 31});
      step(1, 1, 0, 0);
      preq_n += int'(par_req);
    end
    for (int j = 0; j < 6; j++) begin
      step(1, 1, j == 5, j == 2);
      preq_n += int'(par_req);
      if (j == 0) check("ovf_first_drop", {31'd0, ovf_err}, 32'd1);
      if (j == 2) check("ovf_set_wins", {31'd0, ovf_err}, 32'd1);
    end
    check("delayed_preq_cycles", preq_n, 6);
    check("delayed_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    step(1, 0, 0, 1);
    check("ovf_clear_2", {31'd0, ovf_err}, 32'd0);

    // gapped input with disable dropped after index 12
    k = 0; cyc = 0; f_r = 1'b1; act_lo = 0;
    while (k < 32 && cyc < 600) begin
      b_r = 1'($urandom_range(0, 1));
      if (b_r) exp_q.push_back({5'(k), k == 0, k == 31});
      step(f_r, b_r, 0, 0);
      if (b_r) k++;
      if (k == 13) f_r = 1'b0;
      act_lo += int'(!fec_active);
      cyc++;
    end
    check("gap_frame_len", k, 32);
    check("gap_active_held", act_lo, 0);
    check("gap_preq", {31'd0, par_req}, 32'd1);
    step(0, 0, 1, 0);
    check("gap_idle_active", {31'd0, fec_active}, 32'd0);
    check("gap_idle_state", {30'd0, dbg_state}, 32'd0);
    check("gap_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    exp_q.push_back(7'd0);
    step(0, 1, 0, 0);

    // async reset between edges at index 20
    step(1, 0, 0, 0);
    for (int i = 0; i <= 20; i++) begin
      exp_q.push_back({5'(i), i == 0, 1'b0});
      step(1, 1, 0, 0);
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst_outs", {20'd0, outs()}, 32'h001);
    check("async_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check("async_rst_state", {30'd0, dbg_state}, 32'd0);
    fec_en = 0; blk_ena = 0;
    #1 rst = 1'b0;
    step(1, 0, 0, 0);
    exp_q.push_back({5'd0, 1'b1, 1'b0});
    step(1, 1, 0, 0);
    exp_q.push_back({5'd1, 1'b0, 1'b0});
    step(1, 1, 0, 0);
    check("restart_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    step(0, 0, 0, 0);
    check("queue_drain", exp_q.size(), 0);

    // vector table on the 2-block instance
    rst_s = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step_s(vecs[i].f, vecs[i].b, vecs[i].a, vecs[i].c);
      idx_m = blk_vld_s ? blk_idx_s : 5'd0;
      check($sformatf("vec%0d", i),
            {4'd0, blk_vld_s, idx_m, sof_s, eof_s, par_req_s, blk_rdy_s, fec_active_s, ovf_err_s, frame_cnt_s},
            {4'd0, vecs[i].vld, vecs[i].idx, vecs[i].sof, vecs[i].eof, vecs[i].preq, vecs[i].rdy,
             vecs[i].act, vecs[i].ovf, vecs[i].cnt});
    end

    // frame counter wrap with back-to-back 2-block frames
    #1 rst_s = 1'b1;
    #1 rst_s = 1'b0;
    n = 0; last_cnt = 16'd0;
    for (int i = 0; i < 200000 && n < 65535; i++) begin
      step_s(1, 1, 1, 0);
      if (frame_cnt_s != last_cnt) begin
        n++;
        last_cnt = frame_cnt_s;
      end
    end
    check("wrap_preload_frames", n, 65535);
    check("wrap_preload_cnt", {16'd0, frame_cnt_s}, 32'h0000FFFF);
    for (int i = 0; i < 10 && frame_cnt_s == 16'hFFFF; i++) step_s(1, 1, 1, 0);
    check("wrap_zero", {16'd0, frame_cnt_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
